// File: rtl/axis_traffic_gen_if.sv
// axis_traffic_gen_if: AXI-Stream bundle between a traffic source and its sink.
//   tvalid  master -> slave  beat valid
//   tready  slave -> master  sink accepts beat
//   tdata   master -> slave  DATA_WIDTH payload
//   tlast   master -> slave  final beat of a burst (only with AXIS_GEN_TLAST_EN)
interface axis_traffic_gen_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
`ifdef AXIS_GEN_TLAST_EN
  logic                  tlast;
  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
`else
  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);
`endif
endinterface

// File: rtl/axis_traffic_gen.sv
// axis_traffic_gen: AXI-Stream master sourcing a burst of incrementing or LFSR beats.
//   m_axis_clk    clock, rising edge
//   m_axis_rst_n  asynchronous active-low reset
//   start_i       burst request, sampled only when idle
//   num_beats_i   beats in burst, captured with start_i
//   mode_i        0 = incrementing, 1 = 32-bit Galois LFSR; captured with start_i
//   seed_i        first generator value, captured with start_i
//   busy_o        burst in progress (SEND or DONE)
//   done_o        one-cycle pulse at burst end
//   beat_cnt_o    handshakes completed in current/last burst
//   m_axis        AXIS master port (tvalid/tready/tdata[/tlast])
// Optional: define AXIS_GEN_TLAST_EN to drive m_axis.tlast on the final beat.
module axis_traffic_gen #(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   m_axis_clk,
  input  logic                   m_axis_rst_n,
  input  logic                   start_i,
  input  logic [COUNT_WIDTH-1:0] num_beats_i,
  input  logic                   mode_i,
  input  logic [31:0]            seed_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [COUNT_WIDTH-1:0] beat_cnt_o,
  axis_traffic_gen_if.master     m_axis
);
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_e;
  state_e                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
  logic [COUNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic [31:0]            gen_q, gen_d;
  logic                   mode_q, mode_d;
  logic                   hs;
  logic [31:0]            gen_next;
  // Incrementing mode wraps at 2^DATA_WIDTH for free, since only the low bits reach tdata.
  assign hs       = (state_q == SEND) && m_axis.tready;
  assign gen_next = mode_q ? ({1'b0, gen_q[31:1]} ^ (gen_q[0] ? 32'h8020_0003 : 32'h0)) : gen_q + 32'd1;
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    beat_cnt_d  = beat_cnt_q;
    gen_d       = gen_q;
    mode_d      = mode_q;
    case (state_q)
      IDLE: if (start_i) begin
        beat_cnt_d = '0;
        if (num_beats_i != '0) begin
          state_d     = SEND;
          remaining_d = num_beats_i;
          mode_d      = mode_i;
          gen_d       = (mode_i && seed_i == 32'h0) ? 32'h1 : seed_i;
        end else begin
          state_d = DONE;
        end
      end
      SEND: if (hs) begin
        beat_cnt_d  = beat_cnt_q + 1'b1;
        remaining_d = remaining_q - 1'b1;
        gen_d       = gen_next;
        state_d     = (remaining_q == 1) ? DONE : SEND;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge m_axis_clk or negedge m_axis_rst_n) begin
    if (!m_axis_rst_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      beat_cnt_q  <= '0;
      gen_q       <= '0;
      mode_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      beat_cnt_q  <= beat_cnt_d;
      gen_q       <= gen_d;
      mode_q      <= mode_d;
    end
  end
  // All outputs decode registered state, so tvalid never depends on tready.
  assign m_axis.tvalid = state_q == SEND;
  assign m_axis.tdata  = gen_q[DATA_WIDTH-1:0];
`ifdef AXIS_GEN_TLAST_EN
  assign m_axis.tlast  = (state_q == SEND) && (remaining_q == 1);
`endif
  assign busy_o     = state_q != IDLE;
  assign done_o     = state_q == DONE;
  assign beat_cnt_o = beat_cnt_q;
endmodule

// File: tb/tb_axis_traffic_gen.sv
// tb_axis_traffic_gen: randomized self-checking bench for axis_traffic_gen against a stream model.
module tb_axis_traffic_gen;
  localparam int DW = 32;
  localparam int CW = 16;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] num_beats = '0;
  logic          mode = 1'b0;
  logic [31:0]   seed = '0;
  logic          busy, done;
  logic [CW-1:0] beat_cnt;
  int            checks = 0;
  int            errors = 0;
  axis_traffic_gen_if #(.DATA_WIDTH(DW)) axis_if ();
  axis_traffic_gen #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
    .m_axis_clk  (clk),
    .m_axis_rst_n(rst_n),
    .start_i     (start),
    .num_beats_i (num_beats),
    .mode_i      (mode),
    .seed_i      (seed),
    .busy_o      (busy),
    .done_o      (done),
    .beat_cnt_o  (beat_cnt),
    .m_axis      (axis_if)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  // Value of beat i of a burst, computed directly from the generator definition.
  function automatic logic [DW-1:0] beat_val(input logic m, input logic [31:0] s, input int i);
    logic [31:0] st;
    if (!m) begin
      st = s + 32'(i);
      return st[DW-1:0];
    end
    st = (s == 0) ? 32'h1 : s;
    for (int k = 0; k < i; k++) st = st[0] ? ((st >> 1) ^ 32'h8020_0003) : (st >> 1);
    return st[DW-1:0];
  endfunction
  // pat: 0 = ready always high, 1 = random ready, 2 = ready pattern 1,0,0 repeating.
  // poke: pulse start with other settings while busy; it must be ignored.
  task automatic run_burst(input logic m, input logic [31:0] s, input int n, input int pat, input bit poke);
    int  idx = 0;
    int  cyc = 0;
    bit  fin = 0;
    logic rdy;
    @(negedge clk);
    start = 1'b1; mode = m; seed = s; num_beats = CW'(n);
    axis_if.tready = (pat != 1) || $urandom_range(0, 1) == 1;
    @(negedge clk);
    start = 1'b0;
    if (n == 0) begin
      check("zero_tvalid", axis_if.tvalid, 0);
      check("zero_done", done, 1);
      check("zero_cnt", beat_cnt, 0);
      @(negedge clk);
      check("zero_done_end", done, 0);
      check("zero_busy_end", busy, 0);
      return;
    end
    while (!fin && cyc < 2000) begin
      check("beat_cnt", beat_cnt, idx);
      if (idx < n) begin
        check("tvalid", axis_if.tvalid, 1);
        check("busy", busy, 1);
        check("done_early", done, 0);
        check("tdata", axis_if.tdata, beat_val(m, s, idx));
`ifdef AXIS_GEN_TLAST_EN
        check("tlast", axis_if.tlast, idx == n - 1);
`endif
        rdy = pat == 0 ? 1'b1 : pat == 1 ? 1'($urandom_range(0, 1)) : (cyc % 3 == 0);
        axis_if.tready = rdy;
        if (poke && cyc == 1) begin
          start = 1'b1; mode = ~m; seed = ~s; num_beats = 3;
        end else begin
          start = 1'b0;
        end
        if (rdy) idx++;
      end else begin
        start = 1'b0;
        check("tvalid_end", axis_if.tvalid, 0);
        check("done", done, 1);
        check("busy_done", busy, 1);
        @(negedge clk);
        check("done_pulse", done, 0);
        check("busy_idle", busy, 0);
        check("cnt_hold", beat_cnt, n);
        check("tvalid_idle", axis_if.tvalid, 0);
        fin = 1;
      end
      if (!fin) @(negedge clk);
      cyc++;
    end
    check("burst_timeout", fin, 1);
  endtask
  initial begin
    axis_if.tready = 1'b0;
    #12;
    check("rst_tvalid", axis_if.tvalid, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_tdata", axis_if.tdata, 0);
    check("rst_cnt", beat_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_burst(1'b0, 32'hFFFF_FFFE, 4, 0, 0);
    run_burst(1'b1, 32'h0, 3, 0, 0);
    run_burst(1'b0, 32'd10, 5, 2, 0);
    run_burst(1'b0, 32'd0, 0, 0, 0);
    run_burst(1'b1, 32'h1234_5678, 6, 0, 1);
    // Reset after two beats of an eight-beat burst.
    @(negedge clk);
    start = 1'b1; mode = 1'b0; seed = 32'd100; num_beats = 8; axis_if.tready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("pre_rst_tdata", axis_if.tdata, 100);
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_cnt", beat_cnt, 2);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_tvalid", axis_if.tvalid, 0);
    check("mid_rst_cnt", beat_cnt, 0);
    check("mid_rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_done", done, 0);
      check("post_rst_tvalid", axis_if.tvalid, 0);
    end
    run_burst(1'b0, 32'd100, 8, 0, 0);
    for (int t = 0; t < 6; t++)
      run_burst(1'($urandom_range(0, 1)), $urandom, $urandom_range(1, 20), $urandom_range(0, 2), t[0]);
    run_burst(1'b0, 32'hFFFF_FFF0, 40, 1, 0);
    run_burst(1'b1, $urandom, 256, 1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
